button_conditioner: RTL and testbench

//  Input conditioning stage directly upstream of the counter's functional inputs.

---
 rtl/button_conditioner_if.sv | 25 ++
 rtl/button_conditioner.sv | 176 +++++++++++++++++
 tb/tb_button_conditioner.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Pin-side raw inputs and the conditioned outputs of button_conditioner.
// The master drives the raw buttons; the slave (the conditioner) drives the clean outputs.
interface button_conditioner_if;
    logic cnt_raw;
    logic backward_raw;
    logic cnt_pulse;
    logic cnt_level;
    logic backward_level;

    modport master (
        output cnt_raw,
        output backward_raw,
        input  cnt_pulse,
        input  cnt_level,
        input  backward_level
    );

    modport slave (
        input  cnt_raw,
        input  backward_raw,
        output cnt_pulse,
        output cnt_level,
        output backward_level
    );
endinterface

// File: rtl/button_conditioner.sv
// Two-channel synchroniser + debouncer feeding the counter's functional inputs.
// Optional hold-to-repeat on the cnt channel: define BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DB_CYCLES     = 50000,
    parameter int unsigned DB_W          = 16,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input logic                 clk,
    input logic                 nRst,
    button_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        StStableLow,
        StWaitHigh,
        StStableHigh,
        StWaitLow
    } db_state_e;

    localparam int unsigned     NCh     = 2;
    localparam logic [DB_W-1:0] DbLast  = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DbOne   = DB_W'(1);
    localparam logic            DbSingle = (DB_CYCLES == 1);

    // Channel 0 = cnt, channel 1 = backward.
    logic [NCh-1:0] raw;
    logic [NCh-1:0] s;
    logic [NCh-1:0] level;
    logic [NCh-1:0] rise;
    logic [NCh-1:0] sh;

    assign raw = {bus.backward_raw, bus.cnt_raw};

    for (genvar ch = 0; ch < NCh; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DB_W-1:0]        dbcnt_q;
        logic                   level_q;
        db_state_e              state_q;

        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
            end
        end

        assign s[ch]     = sync_q[SYNC_STAGES-1];
        assign level[ch] = level_q;
        assign sh[ch]    = (state_q == StStableHigh);
        // Asserted in the cycle whose edge accepts a new high level.
        assign rise[ch]  = s[ch] && ((state_q == StWaitHigh && dbcnt_q == DbLast) ||
                                     (state_q == StStableLow && DbSingle));

        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                state_q <= StStableLow;
                dbcnt_q <= '0;
                level_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StStableLow: begin
                        if (s[ch]) begin
                            if (DbSingle) begin
                                state_q <= StStableHigh;
                                level_q <= 1'b1;
                            end else begin
                                state_q <= StWaitHigh;
                                dbcnt_q <= DbOne;
                            end
                        end
                    end
                    StWaitHigh: begin
                        if (!s[ch]) begin
                            state_q <= StStableLow;
                            dbcnt_q <= '0;
                        end else if (dbcnt_q == DbLast) begin
                            state_q <= StStableHigh;
                            dbcnt_q <= '0;
                            level_q <= 1'b1;
                        end else begin
                            dbcnt_q <= dbcnt_q + DbOne;
                        end
                    end
                    StStableHigh: begin
                        if (!s[ch]) begin
                            if (DbSingle) begin
                                state_q <= StStableLow;
                                level_q <= 1'b0;
                            end else begin
                                state_q <= StWaitLow;
                                dbcnt_q <= DbOne;
                            end
                        end
                    end
                    StWaitLow: begin
                        if (s[ch]) begin
                            state_q <= StStableHigh;
                            dbcnt_q <= '0;
                        end else if (dbcnt_q == DbLast) begin
                            state_q <= StStableLow;
                            dbcnt_q <= '0;
                            level_q <= 1'b0;
                        end else begin
                            dbcnt_q <= dbcnt_q + DbOne;
                        end
                    end
                    default: begin
                        state_q <= StStableLow;
                        dbcnt_q <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic rpt_fire;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);

    logic [RptW-1:0] rpt_q;
    logic [RptW-1:0] rpt_inc;
    logic            rpt_armed_q;
    logic            rpt_run;

    // Counts only while cnt stays in STABLE_HIGH; the first WAIT_LOW cycle clears it.
    always_comb begin
        rpt_run  = sh[0] && s[0];
        rpt_inc  = rpt_q + 1'b1;
        rpt_fire = rpt_run && (rpt_armed_q ? (rpt_inc == RptW'(REPEAT_PERIOD))
                                           : (rpt_inc == RptW'(REPEAT_DELAY)));
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else if (!rpt_run) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else if (rpt_fire) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b1;
        end else begin
            rpt_q <= rpt_inc;
        end
    end
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_fire       = 1'b0;
`endif

    logic unused_ch;
    assign unused_ch = ^{rise[1], sh};

    logic pulse_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= rise[0] | rpt_fire;
        end
    end

    assign bus.cnt_pulse      = pulse_q;
    assign bus.cnt_level      = level[0];
    assign bus.backward_level = level[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed + randomized bench for button_conditioner against a sliding-window reference model.
// Define BUTTON_CONDITIONER_AUTO_REPEAT_EN in both RTL and bench builds to cover auto-repeat.
module tb_button_conditioner;

    localparam int unsigned Sync = 2;
    localparam int unsigned Db   = 4;
    localparam int unsigned Rd   = 8;
    localparam int unsigned Rp   = 3;
    localparam int unsigned Win  = Sync + Db;

    logic clk = 1'b0;
    logic nRst;

    always #5 clk = ~clk;

    button_conditioner_if bus ();

    button_conditioner #(
        .SYNC_STAGES  (Sync),
        .DB_CYCLES    (Db),
        .DB_W         (16),
        .REPEAT_DELAY (Rd),
        .REPEAT_PERIOD(Rp)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int pulses;
    int exp_n;

    // Model: hist[0] is the raw value captured at the latest edge, hist[i] i edges earlier.
    logic hist_c[Win];
    logic hist_b[Win];
    logic m_lvl_c, m_lvl_b, m_pulse, m_sh;
    int   m_age;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < Win; i++) begin
            hist_c[i] = 1'b0;
            hist_b[i] = 1'b0;
        end
        m_lvl_c = 1'b0;
        m_lvl_b = 1'b0;
        m_pulse = 1'b0;
        m_sh    = 1'b0;
        m_age   = 0;
    endtask

    // A level flips once the synchronised input has shown the opposite value
    // for Db consecutive edges; the synchroniser delays every sample by Sync edges.
    task automatic model_edge();
        logic flip_c, flip_b, sh_new;
        if (!nRst) begin
            model_reset();
        end else begin
            for (int i = Win - 1; i > 0; i--) begin
                hist_c[i] = hist_c[i-1];
                hist_b[i] = hist_b[i-1];
            end
            hist_c[0] = bus.cnt_raw;
            hist_b[0] = bus.backward_raw;
            flip_c = 1'b1;
            flip_b = 1'b1;
            for (int i = Sync; i < Win; i++) begin
                if (hist_c[i] == m_lvl_c) flip_c = 1'b0;
                if (hist_b[i] == m_lvl_b) flip_b = 1'b0;
            end
            m_pulse = flip_c && !m_lvl_c;
            if (flip_c) m_lvl_c = !m_lvl_c;
            if (flip_b) m_lvl_b = !m_lvl_b;
            sh_new = m_lvl_c && hist_c[Sync];
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            if (m_sh && sh_new) begin
                m_age++;
                if (m_age == Rd || (m_age > Rd && (m_age - Rd) % Rp == 0)) m_pulse = 1'b1;
            end else begin
                m_age = 0;
            end
`endif
            m_sh = sh_new;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pulse", bus.cnt_pulse, m_pulse);
        chk("cnt_level", bus.cnt_level, m_lvl_c);
        chk("bwd_level", bus.backward_level, m_lvl_b);
        if (bus.cnt_pulse === 1'b1) pulses++;
    endtask

    task automatic async_reset_check(input string tag);
        nRst = 1'b0;
        model_reset();
        #1;
        chk({tag, "_pulse"}, bus.cnt_pulse, 1'b0);
        chk({tag, "_cnt"}, bus.cnt_level, 1'b0);
        chk({tag, "_bwd"}, bus.backward_level, 1'b0);
    endtask

    initial begin
        int hold_c;
        int hold_b;
        nRst             = 1'b0;
        bus.cnt_raw      = 1'b0;
        bus.backward_raw = 1'b0;
        model_reset();
        pulses = 0;

        // Reset held while inputs toggle, then release with quiet inputs.
        for (int i = 0; i < 6; i++) begin
            bus.cnt_raw      = i[0];
            bus.backward_raw = ~i[1];
            tick();
            chk("t1_rst_cnt", bus.cnt_level, 1'b0);
        end
        bus.cnt_raw      = 1'b0;
        bus.backward_raw = 1'b0;
        nRst             = 1'b1;
        repeat (8) tick();
        chk("t1_idle_lvl", bus.cnt_level, 1'b0);

        // Clean press: level and single pulse on edge 6.
        pulses      = 0;
        bus.cnt_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 5) chk("t2_lvl_e5", bus.cnt_level, 1'b0);
            if (e == 6) chk("t2_lvl_e6", bus.cnt_level, 1'b1);
            if (e == 6) chk("t2_pulse_e6", bus.cnt_pulse, 1'b1);
            if (e == 7) chk("t2_pulse_e7", bus.cnt_pulse, 1'b0);
        end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        chk_int("t2_npulse", pulses, exp_n);
        bus.cnt_raw = 1'b0;
        repeat (12) tick();
        chk("t2_released", bus.cnt_level, 1'b0);

        // Bounce: 3 high, 1 low, then held high.
        pulses      = 0;
        bus.cnt_raw = 1'b1;
        repeat (3) tick();
        bus.cnt_raw = 1'b0;
        tick();
        bus.cnt_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 5) chk("t3_pulse_e5", bus.cnt_pulse, 1'b0);
            if (e == 6) chk("t3_pulse_e6", bus.cnt_pulse, 1'b1);
        end
        chk_int("t3_npulse", pulses, 1);
        bus.cnt_raw = 1'b0;
        repeat (12) tick();

        // Direction channel only.
        pulses           = 0;
        bus.backward_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 5) chk("t4_rise_e5", bus.backward_level, 1'b0);
            if (e == 6) chk("t4_rise_e6", bus.backward_level, 1'b1);
        end
        bus.backward_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 5) chk("t4_fall_e5", bus.backward_level, 1'b1);
            if (e == 6) chk("t4_fall_e6", bus.backward_level, 1'b0);
        end
        chk_int("t4_npulse", pulses, 0);

        // Reset mid-WAIT_HIGH with input held: treated as a fresh press.
        bus.cnt_raw = 1'b1;
        repeat (4) tick();
        async_reset_check("t5_wait_rst");
        tick();
        nRst   = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5) chk("t5_pulse_e5", bus.cnt_pulse, 1'b0);
            if (e == 6) chk("t5_pulse_e6", bus.cnt_pulse, 1'b1);
        end
        chk_int("t5_npulse", pulses, 1);
        chk("t5_lvl_high", bus.cnt_level, 1'b1);
        async_reset_check("t5_high_rst");
        bus.cnt_raw = 1'b0;
        tick();
        nRst = 1'b1;
        repeat (4) tick();

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        // Held press: P=6, repeats at 14, 17, 20, ...
        bus.cnt_raw = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            tick();
            if (e == 14 || e == 17 || e == 20) chk("t6_repeat", bus.cnt_pulse, 1'b1);
            if (e == 13 || e == 15 || e == 16) chk("t6_gap", bus.cnt_pulse, 1'b0);
        end
        bus.cnt_raw = 1'b0;
        repeat (2) tick();
        pulses = 0;
        repeat (10) tick();
        chk_int("t6_stop", pulses, 0);
`endif

        // Randomized independent activity on both channels with occasional resets.
        hold_c = 0;
        hold_b = 0;
        for (int n = 0; n < 800; n++) begin
            if (hold_c == 0) begin
                bus.cnt_raw = 1'($urandom_range(0, 1));
                hold_c      = (($urandom_range(0, 7) == 0) ? 16 : 1) * int'($urandom_range(1, 7));
            end
            if (hold_b == 0) begin
                bus.backward_raw = 1'($urandom_range(0, 1));
                hold_b           = int'($urandom_range(1, 9));
            end
            hold_c--;
            hold_b--;
            if ($urandom_range(0, 249) == 0) begin
                async_reset_check("rnd_rst");
                tick();
                nRst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
